// File: rtl/cg_phase_sequencer_pkg.sv
// Shared types and constants for the CG phase sequencer: FSM state, GAP return target,
// mXv phase-termination modes and a counter-width helper.
package cg_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_INIT = 3'd1,
      ST_VXV  = 3'd2,
      ST_GAP  = 3'd3,
      ST_MXV  = 3'd4,
      ST_DONE = 3'd5
   } state_t;

   typedef enum logic {
      RET_VXV = 1'b0,
      RET_MXV = 1'b1
   } ret_t;

   localparam int MXV_MODE_FIXED     = 0;
   localparam int MXV_MODE_HANDSHAKE = 1;

   // Bits needed to hold the reload value n-1 of an n-cycle interval.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cg_phase_sequencer_if.sv
// Control-side bundle of the CG phase sequencer; the sequencer is the slave,
// the top-level control plus unit cluster together form the master.
interface cg_phase_sequencer_if #(
   parameter int NUM_CH = 4,
   parameter int ITER_W = 16
);
   import cg_seq_pkg::*;

   // Protocol: start is a one-cycle pulse honoured only while idle, with max_iter and
   // ch_enable qualified by it; finish/mxv_done/abort are levels sampled every cycle;
   // halt is a one-cycle pulse at end of run and all other outputs are registered levels.
   logic              start;
   logic [ITER_W-1:0] max_iter;
   logic [NUM_CH-1:0] ch_enable;
   logic [NUM_CH-1:0] finish;
   logic [NUM_CH-1:0] mxv_done;
   logic              abort;
   logic [NUM_CH-1:0] reset_vXv;
   logic [NUM_CH-1:0] reset_mXv;
   logic              busy;
   logic              halt;
   logic [ITER_W-1:0] iter_count;
   logic              timeout;
   state_t            dbg_state;

   modport master (
      output start, max_iter, ch_enable, finish, mxv_done, abort,
      input  reset_vXv, reset_mXv, busy, halt, iter_count, timeout, dbg_state
   );

   modport slave (
      input  start, max_iter, ch_enable, finish, mxv_done, abort,
      output reset_vXv, reset_mXv, busy, halt, iter_count, timeout, dbg_state
   );

endinterface

// File: rtl/cg_phase_sequencer_down_counter.sv
// Loadable down counter that saturates at zero; o_expired flags a zero count so an
// interval of n cycles is timed by loading n-1 on entry.
module seq_down_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_expired
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - W'(1);
      end
   end

   assign o_expired = (r_count == '0);

endmodule

// File: rtl/cg_phase_sequencer.sv
// Alternates NUM_CH vXv and mXv units between run and hold for each CG iteration, with
// iteration limit, per-channel enables, fixed or handshake mXv phase, abort and watchdog.
module cg_phase_sequencer #(
   parameter int NUM_CH      = 4,
   parameter int ITER_W      = 16,
   parameter int INIT_CYCLES = 2,
   parameter int GAP_CYCLES  = 1,
   parameter int MXV_MODE    = 0,
   parameter int MXV_CYCLES  = 4,
   parameter int WDOG_CYCLES = 4096
) (
   input logic                 clk,
   input logic                 reset,
   cg_phase_sequencer_if.slave bus
);
   import cg_seq_pkg::*;

   localparam int PH_IG  = (INIT_CYCLES > GAP_CYCLES) ? INIT_CYCLES : GAP_CYCLES;
   localparam int PH_MAX = (PH_IG > MXV_CYCLES) ? PH_IG : MXV_CYCLES;
   localparam int PH_W   = cnt_width(PH_MAX);
   localparam int WD_W   = cnt_width(WDOG_CYCLES);

   localparam logic [PH_W-1:0] INIT_LD = PH_W'(INIT_CYCLES - 1);
   localparam logic [PH_W-1:0] GAP_LD  = PH_W'(GAP_CYCLES - 1);
   localparam logic [PH_W-1:0] MXV_LD  = PH_W'(MXV_CYCLES - 1);
   localparam logic [WD_W-1:0] WD_LD   = WD_W'(WDOG_CYCLES - 1);

   state_t              r_state;
   ret_t                r_ret;
   logic [NUM_CH-1:0]   r_en;
   logic [ITER_W-1:0]   r_max_iter;
   logic [ITER_W-1:0]   r_iter;
   logic [NUM_CH-1:0]   r_reset_vxv;
   logic [NUM_CH-1:0]   r_reset_mxv;
   logic                r_busy;
   logic                r_halt;
   logic                r_timeout;

   state_t              w_next;
   logic                w_in_run;
   logic                w_abort;
   logic                w_wd_hit;
   logic                w_vxv_end;
   logic                w_mxv_end;
   logic                w_last;
   logic [ITER_W-1:0]   w_iter_nxt;
   logic                w_ph_load;
   logic [PH_W-1:0]     w_ph_val;
   logic                w_ph_zero;
   logic                w_wd_load;
   logic                w_wd_zero;
   logic                w_iter_inc;

   // Phase timer covers INIT, GAP and fixed-length MXV; only one is ever live.
   seq_down_counter #(.W(PH_W)) u_phase_cnt (
      .clk        (clk),
      .rst_n      (reset),
      .i_load     (w_ph_load),
      .i_load_val (w_ph_val),
      .i_dec      (1'b1),
      .o_expired  (w_ph_zero)
   );

   seq_down_counter #(.W(WD_W)) u_wdog_cnt (
      .clk        (clk),
      .rst_n      (reset),
      .i_load     (w_wd_load),
      .i_load_val (WD_LD),
      .i_dec      (1'b1),
      .o_expired  (w_wd_zero)
   );

   always_comb begin
      w_in_run   = (r_state == ST_INIT) || (r_state == ST_VXV) ||
                   (r_state == ST_GAP)  || (r_state == ST_MXV);
      w_abort    = bus.abort && w_in_run;
      w_wd_hit   = ((r_state == ST_VXV) || (r_state == ST_MXV)) && w_wd_zero;
      w_vxv_end  = ((bus.finish & r_en) == r_en);
      w_mxv_end  = (MXV_MODE == MXV_MODE_HANDSHAKE) ? ((bus.mxv_done & r_en) == r_en)
                                                     : w_ph_zero;
      w_iter_nxt = r_iter + ITER_W'(1);
      w_last     = (r_max_iter != '0) && (w_iter_nxt == r_max_iter);

      w_next     = r_state;
      w_ph_load  = 1'b0;
      w_ph_val   = INIT_LD;
      w_wd_load  = 1'b0;
      w_iter_inc = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               if (bus.ch_enable == '0) begin
                  w_next = ST_DONE;
               end else begin
                  w_next    = ST_INIT;
                  w_ph_load = 1'b1;
                  w_ph_val  = INIT_LD;
               end
            end
         end
         ST_INIT: begin
            if (w_ph_zero) begin
               w_next    = ST_VXV;
               w_wd_load = 1'b1;
            end
         end
         ST_VXV: begin
            if (w_vxv_end) begin
               w_next    = ST_GAP;
               w_ph_load = 1'b1;
               w_ph_val  = GAP_LD;
            end
         end
         ST_GAP: begin
            if (w_ph_zero) begin
               w_wd_load = 1'b1;
               if (r_ret == RET_MXV) begin
                  w_next    = ST_MXV;
                  w_ph_load = 1'b1;
                  w_ph_val  = MXV_LD;
               end else begin
                  w_next = ST_VXV;
               end
            end
         end
         ST_MXV: begin
            if (w_mxv_end) begin
               w_iter_inc = 1'b1;
               if (w_last) begin
                  w_next = ST_DONE;
               end else begin
                  w_next    = ST_GAP;
                  w_ph_load = 1'b1;
                  w_ph_val  = GAP_LD;
               end
            end
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase

      // Abort and watchdog pre-empt any phase completion seen on the same cycle.
      if (w_abort || w_wd_hit) begin
         w_next     = ST_DONE;
         w_ph_load  = 1'b0;
         w_wd_load  = 1'b0;
         w_iter_inc = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_ret       <= RET_MXV;
         r_en        <= '0;
         r_max_iter  <= '0;
         r_iter      <= '0;
         r_reset_vxv <= '1;
         r_reset_mxv <= '1;
         r_busy      <= 1'b0;
         r_halt      <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_halt      <= (w_next == ST_DONE);
         r_busy      <= (w_next == ST_INIT) || (w_next == ST_VXV) ||
                        (w_next == ST_GAP)  || (w_next == ST_MXV);
         r_reset_vxv <= (w_next == ST_VXV) ? ~r_en : '1;
         r_reset_mxv <= (w_next == ST_MXV) ? ~r_en : '1;

         if ((r_state == ST_IDLE) && bus.start) begin
            r_en       <= bus.ch_enable;
            r_max_iter <= bus.max_iter;
            r_iter     <= '0;
            r_timeout  <= 1'b0;
         end

         if ((r_state == ST_VXV) && (w_next == ST_GAP)) begin
            r_ret <= RET_MXV;
         end else if ((r_state == ST_MXV) && (w_next == ST_GAP)) begin
            r_ret <= RET_VXV;
         end

         if (w_iter_inc) begin
            r_iter <= w_iter_nxt;
         end

         if (w_wd_hit && !w_abort) begin
            r_timeout <= 1'b1;
         end
      end
   end

   assign bus.reset_vXv  = r_reset_vxv;
   assign bus.reset_mXv  = r_reset_mxv;
   assign bus.busy       = r_busy;
   assign bus.halt       = r_halt;
   assign bus.iter_count = r_iter;
   assign bus.timeout    = r_timeout;
   assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_cg_phase_sequencer.sv
// Directed bench for cg_phase_sequencer: a per-cycle vector table for the nominal runs,
// then hand-written sequences for watchdog, abort, handshake mXv and mid-run reset.
module tb_cg_phase_sequencer;
   import cg_seq_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;

   typedef struct {
      logic        start;
      logic [3:0]  en;
      logic [15:0] max_iter;
      logic [3:0]  finish;
      logic        abort;
      state_t      st;
      logic [3:0]  rv;
      logic [3:0]  rm;
      logic        busy;
      logic        halt;
      logic [15:0] iter;
      logic        to;
   } vec_t;

   vec_t vecs[$];

   cg_phase_sequencer_if #(.NUM_CH(4), .ITER_W(16)) if0 ();
   cg_phase_sequencer_if #(.NUM_CH(4), .ITER_W(16)) if1 ();

   cg_phase_sequencer #(
      .NUM_CH(4), .ITER_W(16), .INIT_CYCLES(2), .GAP_CYCLES(1),
      .MXV_MODE(MXV_MODE_FIXED), .MXV_CYCLES(4), .WDOG_CYCLES(16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (if0)
   );

   cg_phase_sequencer #(
      .NUM_CH(4), .ITER_W(16), .INIT_CYCLES(2), .GAP_CYCLES(1),
      .MXV_MODE(MXV_MODE_HANDSHAKE), .MXV_CYCLES(4), .WDOG_CYCLES(16)
   ) dut_hs (
      .clk   (clk),
      .reset (reset),
      .bus   (if1)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_dut0(input string tag, input state_t st, input logic [3:0] rv,
                           input logic [3:0] rm, input logic b, input logic h,
                           input logic [15:0] it, input logic to);
      chk($sformatf("%s.state", tag), 32'(if0.dbg_state), 32'(st));
      chk($sformatf("%s.reset_vXv", tag), 32'(if0.reset_vXv), 32'(rv));
      chk($sformatf("%s.reset_mXv", tag), 32'(if0.reset_mXv), 32'(rm));
      chk($sformatf("%s.busy", tag), 32'(if0.busy), 32'(b));
      chk($sformatf("%s.halt", tag), 32'(if0.halt), 32'(h));
      chk($sformatf("%s.iter_count", tag), 32'(if0.iter_count), 32'(it));
      chk($sformatf("%s.timeout", tag), 32'(if0.timeout), 32'(to));
   endtask

   task automatic add(input logic s, input logic [3:0] en, input logic [15:0] mx,
                      input logic [3:0] f, input logic ab, input state_t st,
                      input logic [3:0] rv, input logic [3:0] rm, input logic b,
                      input logic h, input logic [15:0] it, input logic to);
      vec_t v;
      v.start = s;  v.en = en;  v.max_iter = mx;  v.finish = f;  v.abort = ab;
      v.st = st;    v.rv = rv;  v.rm = rm;        v.busy = b;    v.halt = h;
      v.iter = it;  v.to = to;
      vecs.push_back(v);
   endtask

   initial begin
      reset = 1'b0;
      if0.start = 0; if0.max_iter = 0; if0.ch_enable = 0; if0.finish = 0; if0.mxv_done = 0; if0.abort = 0;
      if1.start = 0; if1.max_iter = 0; if1.ch_enable = 0; if1.finish = 0; if1.mxv_done = 0; if1.abort = 0;

      // Two full iterations, all channels, finish in the third VXV cycle.
      add(1, 4'hF, 16'd2, 4'h0, 0, ST_INIT, 4'hF, 4'hF, 1, 0, 16'd0, 0);
      add(0, 4'hF, 16'd2, 4'h0, 0, ST_INIT, 4'hF, 4'hF, 1, 0, 16'd0, 0);
      add(0, 4'hF, 16'd2, 4'h0, 0, ST_VXV,  4'h0, 4'hF, 1, 0, 16'd0, 0);
      add(0, 4'hF, 16'd2, 4'h0, 0, ST_VXV,  4'h0, 4'hF, 1, 0, 16'd0, 0);
      add(0, 4'hF, 16'd2, 4'h0, 0, ST_VXV,  4'h0, 4'hF, 1, 0, 16'd0, 0);
      add(0, 4'hF, 16'd2, 4'hF, 0, ST_GAP,  4'hF, 4'hF, 1, 0, 16'd0, 0);
      add(0, 4'hF, 16'd2, 4'h0, 0, ST_MXV,  4'hF, 4'h0, 1, 0, 16'd0, 0);
      add(0, 4'hF, 16'd2, 4'h0, 0, ST_MXV,  4'hF, 4'h0, 1, 0, 16'd0, 0);
      add(0, 4'hF, 16'd2, 4'h0, 0, ST_MXV,  4'hF, 4'h0, 1, 0, 16'd0, 0);
      add(0, 4'hF, 16'd2, 4'h0, 0, ST_MXV,  4'hF, 4'h0, 1, 0, 16'd0, 0);
      add(0, 4'hF, 16'd2, 4'h0, 0, ST_GAP,  4'hF, 4'hF, 1, 0, 16'd1, 0);
      add(0, 4'hF, 16'd2, 4'h0, 0, ST_VXV,  4'h0, 4'hF, 1, 0, 16'd1, 0);
      add(0, 4'hF, 16'd2, 4'h0, 0, ST_VXV,  4'h0, 4'hF, 1, 0, 16'd1, 0);
      add(0, 4'hF, 16'd2, 4'h0, 0, ST_VXV,  4'h0, 4'hF, 1, 0, 16'd1, 0);
      add(0, 4'hF, 16'd2, 4'hF, 0, ST_GAP,  4'hF, 4'hF, 1, 0, 16'd1, 0);
      add(0, 4'hF, 16'd2, 4'h0, 0, ST_MXV,  4'hF, 4'h0, 1, 0, 16'd1, 0);
      add(0, 4'hF, 16'd2, 4'h0, 0, ST_MXV,  4'hF, 4'h0, 1, 0, 16'd1, 0);
      add(0, 4'hF, 16'd2, 4'h0, 0, ST_MXV,  4'hF, 4'h0, 1, 0, 16'd1, 0);
      add(0, 4'hF, 16'd2, 4'h0, 0, ST_MXV,  4'hF, 4'h0, 1, 0, 16'd1, 0);
      add(0, 4'hF, 16'd2, 4'h0, 0, ST_DONE, 4'hF, 4'hF, 0, 1, 16'd2, 0);
      add(0, 4'hF, 16'd2, 4'h0, 0, ST_IDLE, 4'hF, 4'hF, 0, 0, 16'd2, 0);
      add(0, 4'hF, 16'd2, 4'h0, 0, ST_IDLE, 4'hF, 4'hF, 0, 0, 16'd2, 0);
      // Channels 0 and 2 only; finish on disabled channels alone must not end VXV.
      add(1, 4'h5, 16'd1, 4'h0, 0, ST_INIT, 4'hF, 4'hF, 1, 0, 16'd0, 0);
      add(0, 4'h5, 16'd1, 4'h0, 0, ST_INIT, 4'hF, 4'hF, 1, 0, 16'd0, 0);
      add(0, 4'h5, 16'd1, 4'h0, 0, ST_VXV,  4'hA, 4'hF, 1, 0, 16'd0, 0);
      add(0, 4'h5, 16'd1, 4'hA, 0, ST_VXV,  4'hA, 4'hF, 1, 0, 16'd0, 0);
      add(0, 4'h5, 16'd1, 4'h5, 0, ST_GAP,  4'hF, 4'hF, 1, 0, 16'd0, 0);
      add(0, 4'h5, 16'd1, 4'h0, 0, ST_MXV,  4'hF, 4'hA, 1, 0, 16'd0, 0);
      add(0, 4'h5, 16'd1, 4'h0, 0, ST_MXV,  4'hF, 4'hA, 1, 0, 16'd0, 0);
      add(0, 4'h5, 16'd1, 4'h0, 0, ST_MXV,  4'hF, 4'hA, 1, 0, 16'd0, 0);
      add(0, 4'h5, 16'd1, 4'h0, 0, ST_MXV,  4'hF, 4'hA, 1, 0, 16'd0, 0);
      add(0, 4'h5, 16'd1, 4'h0, 0, ST_DONE, 4'hF, 4'hF, 0, 1, 16'd1, 0);
      add(0, 4'h5, 16'd1, 4'h0, 0, ST_IDLE, 4'hF, 4'hF, 0, 0, 16'd1, 0);

      #12;
      chk_dut0("reset", ST_IDLE, 4'hF, 4'hF, 0, 0, 16'd0, 0);
      chk("reset.hs_reset_vXv", 32'(if1.reset_vXv), 32'hF);
      chk("reset.hs_busy", 32'(if1.busy), 32'h0);
      reset = 1'b1;
      step();
      chk_dut0("post_reset", ST_IDLE, 4'hF, 4'hF, 0, 0, 16'd0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         if0.start     = vecs[i].start;
         if0.ch_enable = vecs[i].en;
         if0.max_iter  = vecs[i].max_iter;
         if0.finish    = vecs[i].finish;
         if0.abort     = vecs[i].abort;
         step();
         chk_dut0($sformatf("vec%0d", i), vecs[i].st, vecs[i].rv, vecs[i].rm,
                  vecs[i].busy, vecs[i].halt, vecs[i].iter, vecs[i].to);
      end
      if0.start = 0; if0.finish = 0; if0.abort = 0;

      // Watchdog: finish never arrives, VXV lasts exactly 16 cycles.
      if0.ch_enable = 4'hF; if0.max_iter = 16'd0; if0.start = 1;
      step(); if0.start = 0;
      step(); step();
      for (int c = 1; c <= 16; c++) begin
         chk($sformatf("wdog.c%0d.state", c), 32'(if0.dbg_state), 32'(ST_VXV));
         chk($sformatf("wdog.c%0d.timeout", c), 32'(if0.timeout), 32'h0);
         step();
      end
      chk_dut0("wdog.done", ST_DONE, 4'hF, 4'hF, 0, 1, 16'd0, 1);
      step();
      chk_dut0("wdog.idle", ST_IDLE, 4'hF, 4'hF, 0, 0, 16'd0, 1);

      // Abort in IDLE is ignored.
      if0.abort = 1; step(); if0.abort = 0;
      chk_dut0("abort_idle", ST_IDLE, 4'hF, 4'hF, 0, 0, 16'd0, 1);

      // New start clears timeout; start while busy ignored; abort beats finish.
      if0.start = 1; step(); if0.start = 0;
      chk_dut0("ab.init", ST_INIT, 4'hF, 4'hF, 1, 0, 16'd0, 0);
      step(); step();
      chk_dut0("ab.vxv", ST_VXV, 4'h0, 4'hF, 1, 0, 16'd0, 0);
      if0.start = 1; step(); if0.start = 0;
      chk_dut0("ab.start_busy", ST_VXV, 4'h0, 4'hF, 1, 0, 16'd0, 0);
      if0.finish = 4'hF; if0.abort = 1; step(); if0.finish = 0; if0.abort = 0;
      chk_dut0("ab.done", ST_DONE, 4'hF, 4'hF, 0, 1, 16'd0, 0);
      step();
      chk_dut0("ab.idle", ST_IDLE, 4'hF, 4'hF, 0, 0, 16'd0, 0);

      // No channel enabled: straight to DONE.
      if0.ch_enable = 4'h0; if0.start = 1; step(); if0.start = 0;
      chk_dut0("en0.done", ST_DONE, 4'hF, 4'hF, 0, 1, 16'd0, 0);
      step();
      chk_dut0("en0.idle", ST_IDLE, 4'hF, 4'hF, 0, 0, 16'd0, 0);

      // Handshake mXv: completion bits staggered over MXV cycles 2,5,7,9.
      if1.ch_enable = 4'hF; if1.max_iter = 16'd1; if1.start = 1;
      step(); if1.start = 0;
      step(); step();
      chk("hs.vxv", 32'(if1.dbg_state), 32'(ST_VXV));
      if1.finish = 4'hF; step(); if1.finish = 0;
      chk("hs.gap", 32'(if1.dbg_state), 32'(ST_GAP));
      step();
      for (int c = 1; c <= 9; c++) begin
         chk($sformatf("hs.c%0d.state", c), 32'(if1.dbg_state), 32'(ST_MXV));
         chk($sformatf("hs.c%0d.reset_mXv", c), 32'(if1.reset_mXv), 32'h0);
         if1.mxv_done = {(c >= 9), (c >= 7), (c >= 5), (c >= 2)};
         step();
      end
      if1.mxv_done = 4'h0;
      chk("hs.done.state", 32'(if1.dbg_state), 32'(ST_DONE));
      chk("hs.done.halt", 32'(if1.halt), 32'h1);
      chk("hs.done.iter", 32'(if1.iter_count), 32'h1);
      step();
      chk("hs.idle.halt", 32'(if1.halt), 32'h0);

      // Reset in the middle of an MXV phase, then a clean run from iteration 0.
      if0.ch_enable = 4'hF; if0.max_iter = 16'd0; if0.start = 1;
      step(); if0.start = 0;
      step(); step();
      if0.finish = 4'hF; step(); if0.finish = 0;
      step(); step();
      chk_dut0("rst.mxv", ST_MXV, 4'hF, 4'h0, 1, 0, 16'd0, 0);
      #2 reset = 1'b0;
      #1;
      chk_dut0("rst.async", ST_IDLE, 4'hF, 4'hF, 0, 0, 16'd0, 0);
      @(negedge clk);
      reset = 1'b1;
      step();
      chk_dut0("rst.idle", ST_IDLE, 4'hF, 4'hF, 0, 0, 16'd0, 0);
      if0.max_iter = 16'd1; if0.start = 1; step(); if0.start = 0;
      chk_dut0("rerun.init", ST_INIT, 4'hF, 4'hF, 1, 0, 16'd0, 0);
      step(); step();
      chk_dut0("rerun.vxv", ST_VXV, 4'h0, 4'hF, 1, 0, 16'd0, 0);
      if0.finish = 4'hF; step(); if0.finish = 0;
      step(); step(); step(); step();
      chk_dut0("rerun.mxv4", ST_MXV, 4'hF, 4'h0, 1, 0, 16'd0, 0);
      step();
      chk_dut0("rerun.done", ST_DONE, 4'hF, 4'hF, 0, 1, 16'd1, 0);
      step();
      chk_dut0("rerun.idle", ST_IDLE, 4'hF, 4'hF, 0, 0, 16'd1, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
